// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken-branch and memory-wait hazards,
// plus saturating stall/flush counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_write_reg,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMemWait = 2'd2,
    StFlush   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             timeout_q;
  logic             mem_hold, load_use, flush_evt, timeout_hit;

  assign mem_hold = mem_req & ~mem_ready;
  // ID holds a squashed instruction right after a flush, so its operands are meaningless.
  assign load_use = ex_mem_read & ex_reg_write & (ex_write_reg != 5'd0) &
                    ((ex_write_reg == id_rs) | (id_uses_rt & (ex_write_reg == id_rt))) &
                    (state_q != StFlush);

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    flush_evt    = 1'b0;
    state_d      = StRun;
    if (rst) begin
      pc_en        = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (mem_hold) begin
      // Freezing EX keeps any taken branch in place; it is acted on once memory completes.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      state_d      = StMemWait;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_evt  = 1'b1;
      state_d    = StFlush;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      state_d    = StLuStall;
    end
  end

  always_comb begin
    wait_cnt_d = 8'd0;
    if (mem_hold) begin
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
    end
  end

  assign timeout_hit = ~rst & mem_hold & (wait_cnt_d == 8'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      wait_cnt_q <= 8'd0;
      stall_q    <= '0;
      flush_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (timeout_hit) timeout_q <= 1'b1;
      if (!pc_en && stall_q != CntMax) stall_q <= stall_q + 1'b1;
      if (flush_evt && flush_q != CntMax) flush_q <= flush_q + 1'b1;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  assign mem_timeout  = timeout_q | timeout_hit;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios plus a randomized run
// compared against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;
  localparam int MW = 15;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_write_reg;
  logic id_uses_rt, ex_mem_read, ex_reg_write, branch_taken, mem_req, mem_ready;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_timeout;
  logic [1:0] state;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_state, m_stall, m_flush, m_wait;
  bit m_to;
  bit e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmem, e_bub, e_to;
  int e_next;
  bit e_flush_evt;

  pipeline_hazard_ctrl #(.CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble), .state(state),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    bit hold, lu;
    int nw;
    hold = mem_req && !mem_ready;
    lu = ex_mem_read && ex_reg_write && ex_write_reg != 0 &&
         (ex_write_reg == id_rs || (id_uses_rt && ex_write_reg == id_rt)) && m_state != 3;
    {e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmem, e_bub} = 7'b1101010;
    e_flush_evt = 0;
    e_next = 0;
    if (rst) begin
      e_pc = 0; e_iffl = 1; e_idexfl = 1; e_bub = 1;
    end else if (hold) begin
      e_pc = 0; e_ifen = 0; e_idexen = 0; e_exmem = 0; e_bub = 1; e_next = 2;
    end else if (branch_taken) begin
      e_iffl = 1; e_idexfl = 1; e_flush_evt = 1; e_next = 3;
    end else if (lu) begin
      e_pc = 0; e_ifen = 0; e_idexfl = 1; e_next = 1;
    end
    nw = hold ? ((m_wait + 1 > 255) ? 255 : m_wait + 1) : 0;
    e_to = m_to || (!rst && hold && nw == MW);
  endtask

  // Applies the clock edge to both DUT and model, then leaves 1 time unit for outputs to settle.
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
    end else begin
      m_to = e_to;
      m_wait = (mem_req && !mem_ready) ? ((m_wait + 1 > 255) ? 255 : m_wait + 1) : 0;
      if (!e_pc && m_stall < CMAX) m_stall++;
      if (e_flush_evt && m_flush < CMAX) m_flush++;
      m_state = e_next;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_reg_write = 0;
    ex_write_reg = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; branch_taken = 1; mem_req = 1;
    #1;
    n_tests++;
    if ({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble} !== 7'b0111111)
    begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0111111",
               {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble});
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (state !== 2'd0 || stall_cycles !== 0 || flush_count !== 0 || mem_timeout !== 0) begin
      n_fail++;
      $display("FAIL reset_state: got st=%0d stall=%0d flush=%0d to=%b want 0 0 0 0",
               state, stall_cycles, flush_count, mem_timeout);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 8; id_rs = 8; id_rt = 3;
    #1;
    n_tests++;
    if ({pc_en, ifid_en, idex_flush, idex_en, exmem_en} !== 5'b00111) begin
      n_fail++;
      $display("FAIL load_use_stall: got %b want 00111",
               {pc_en, ifid_en, idex_flush, idex_en, exmem_en});
    end
    tick();
    n_tests++;
    if (state !== 2'd1) begin
      n_fail++; $display("FAIL load_use_state: got %0d want 1", state);
    end
    idle_inputs();
    #1;
    n_tests++;
    if ({pc_en, ifid_en, idex_en, exmem_en} !== 4'b1111 || stall_cycles !== 1) begin
      n_fail++;
      $display("FAIL load_use_release: got en=%b stall=%0d want 1111 1",
               {pc_en, ifid_en, idex_en, exmem_en}, stall_cycles);
    end
    tick();
    // rt only counts when the instruction actually reads it
    ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 5; id_rs = 1; id_rt = 5; id_uses_rt = 0;
    #1;
    n_tests++;
    if (pc_en !== 1'b1) begin
      n_fail++; $display("FAIL load_use_rt_unused: got pc_en=%b want 1", pc_en);
    end
    id_uses_rt = 1;
    #1;
    n_tests++;
    if (pc_en !== 1'b0) begin
      n_fail++; $display("FAIL load_use_rt_used: got pc_en=%b want 0", pc_en);
    end
    tick();
  endtask

  task automatic test_load_zero();
    do_reset();
    ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 0; id_rs = 0;
    #1;
    n_tests++;
    if (pc_en !== 1'b1 || idex_flush !== 1'b0) begin
      n_fail++; $display("FAIL load_zero: got pc_en=%b idex_flush=%b want 1 0", pc_en, idex_flush);
    end
    tick();
    n_tests++;
    if (state !== 2'd0 || stall_cycles !== 0) begin
      n_fail++;
      $display("FAIL load_zero_state: got st=%0d stall=%0d want 0 0", state, stall_cycles);
    end
  endtask

  task automatic test_branch_then_lu();
    do_reset();
    branch_taken = 1;
    #1;
    n_tests++;
    if ({ifid_flush, idex_flush, pc_en, ifid_en} !== 4'b1111) begin
      n_fail++;
      $display("FAIL branch_flush: got %b want 1111", {ifid_flush, idex_flush, pc_en, ifid_en});
    end
    tick();
    n_tests++;
    if (flush_count !== 1 || state !== 2'd3) begin
      n_fail++;
      $display("FAIL branch_count: got cnt=%0d st=%0d want 1 3", flush_count, state);
    end
    branch_taken = 0; ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 9; id_rs = 9;
    #1;
    n_tests++;
    if (pc_en !== 1'b1 || idex_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_masks_lu: got pc_en=%b idex_flush=%b want 1 0", pc_en, idex_flush);
    end
    tick();
    n_tests++;
    if (state !== 2'd0 || stall_cycles !== 0) begin
      n_fail++;
      $display("FAIL flush_return: got st=%0d stall=%0d want 0 0", state, stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1; mem_ready = 0; branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if ({pc_en, ifid_en, idex_en, exmem_en, memwb_bubble, ifid_flush, idex_flush} !== 7'b0000100)
      begin
        n_fail++;
        $display("FAIL mem_wait_hold[%0d]: got %b want 0000100", i,
                 {pc_en, ifid_en, idex_en, exmem_en, memwb_bubble, ifid_flush, idex_flush});
      end
      tick();
    end
    n_tests++;
    if (stall_cycles !== 3 || flush_count !== 0 || state !== 2'd2) begin
      n_fail++;
      $display("FAIL mem_wait_counts: got stall=%0d flush=%0d st=%0d want 3 0 2",
               stall_cycles, flush_count, state);
    end
    mem_ready = 1;
    #1;
    n_tests++;
    if (ifid_flush !== 1'b1 || pc_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mem_wait_branch: got ifid_flush=%b pc_en=%b want 1 1", ifid_flush, pc_en);
    end
    tick();
    n_tests++;
    if (flush_count !== 1 || state !== 2'd3) begin
      n_fail++;
      $display("FAIL mem_wait_after: got flush=%0d st=%0d want 1 3", flush_count, state);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 20; i++) begin
      #1;
      n_tests++;
      if (mem_timeout !== (i >= MW)) begin
        n_fail++;
        $display("FAIL timeout_cycle%0d: got %b want %b", i, mem_timeout, (i >= MW));
      end
      tick();
    end
    n_tests++;
    if (stall_cycles !== CMAX[CW-1:0]) begin
      n_fail++; $display("FAIL stall_saturate: got %0d want %0d", stall_cycles, CMAX);
    end
    mem_ready = 1;
    tick();
    mem_req = 0;
    tick();
    n_tests++;
    if (mem_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b want 1", mem_timeout);
    end
    do_reset();
    n_tests++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_reset: got %b want 0", mem_timeout);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_req = 1; mem_ready = 0; branch_taken = 1;
    repeat (3) tick();
    rst = 1;
    #1;
    n_tests++;
    if (pc_en !== 1'b0 || memwb_bubble !== 1'b1 || exmem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_wait: got pc_en=%b bub=%b exmem_en=%b want 0 1 1",
               pc_en, memwb_bubble, exmem_en);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (state !== 2'd0 || stall_cycles !== 0 || flush_count !== 0 || pc_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_abort: got st=%0d stall=%0d flush=%0d pc_en=%b want 0 0 0 1",
               state, stall_cycles, flush_count, pc_en);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom);
      ex_mem_read  = 1'($urandom);
      ex_reg_write = ($urandom_range(0, 3) != 0);
      ex_write_reg = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 4) == 0);
      mem_req      = ($urandom_range(0, 2) == 0);
      mem_ready    = ($urandom_range(0, 9) < 3);
      #1;
      model_eval();
      n_tests++;
      if ({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_timeout}
            !== {e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmem, e_bub, e_to} ||
          state !== 2'(m_state) || stall_cycles !== CW'(m_stall) ||
          flush_count !== CW'(m_flush)) begin
        n_fail++;
        if (bad++ < 10)
          $display("FAIL random[%0d]: got ctl=%b st=%0d stall=%0d flush=%0d want %b %0d %0d %0d",
                   i, {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble,
                   mem_timeout}, state, stall_cycles, flush_count,
                   {e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmem, e_bub, e_to},
                   m_state, m_stall, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
    idle_inputs();
    #1;
    test_reset();
    test_load_use();
    test_load_zero();
    test_branch_then_lu();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It detects load-use hazards (ID vs EX), taken-branch redirects (EX) and data-memory wait states (MEM). It drives per-stage enable, flush and bubble controls to PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also keeps stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
CNT_W, 16, width of the saturating performance counters
MAX_WAIT, 15, number of consecutive MEM_WAIT cycles that sets mem_timeout (legal range 1..255)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_read  in  1  EX instruction is a load
ex_reg_write  in  1  EX instruction writes a register
ex_write_reg  in  5  destination register of the EX instruction
branch_taken  in  1  EX resolved a taken branch or jump this cycle
mem_req  in  1  MEM stage has an active load/store
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID loads a NOP
idex_en  out  1  ID/EX register enable
idex_flush  out  1  ID/EX loads a bubble (all control bits 0)
exmem_en  out  1  EX/MEM register enable
memwb_bubble  out  1  MEM/WB loads zeros (write_reg=0, MemtoReg=0, DataC=0)
state  out  2  RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0
flush_count  out  CNT_W  saturating count of branch flushes
mem_timeout  out  1  sticky: a MEM_WAIT lasted MAX_WAIT cycles

Behaviour:
Combinational terms:
- mem_hold = mem_req & ~mem_ready.
- load_use = ex_mem_read & ex_reg_write & (ex_write_reg != 0) & ((ex_write_reg == id_rs) | (id_uses_rt & ex_write_reg == id_rt)) & (state != FLUSH).

Outputs are Mealy, evaluated same cycle in strict priority order:
1. rst=1: pc_en=0, ifid_flush=1, idex_flush=1, memwb_bubble=1; all other enables 1.
2. mem_hold: pc_en=ifid_en=idex_en=exmem_en=0; memwb_bubble=1; both flushes 0. branch_taken and load_use are ignored this cycle. The branch is re-seen once the pipeline unfreezes, because EX is held.
3. branch_taken: all enables 1; ifid_flush=1, idex_flush=1.
4. load_use: pc_en=0, ifid_en=0, idex_flush=1; idex_en=exmem_en=1.
5. Default: all enables 1; flushes and bubble 0.

Next state, from any state, same priority: rst→RUN; mem_hold→MEM_WAIT; branch_taken→FLUSH; load_use→LU_STALL; otherwise RUN.
- FLUSH lasts exactly one cycle unless another event occurs. It masks load_use because ID holds a squashed instruction.
- Load-use stall is exactly 1 cycle. The load moves to MEM, so the condition clears naturally.

Counters:
- stall_cycles increments when pc_en=0 and rst=0. Saturates at all-ones.
- flush_count increments in cycles where priority 3 fires. Saturates at all-ones.
- Internal 8-bit wait_cnt: cleared whenever mem_hold=0, incremented each mem_hold cycle, saturates at 255.
- mem_timeout is set in the cycle wait_cnt reaches MAX_WAIT. It stays high until rst; nothing else clears it.

Reset: state=RUN, counters=0, wait_cnt=0, mem_timeout=0. rst asserted mid-stall or mid-wait aborts immediately, with no pending stall carried over.

Test Plan:
- Load-use on rs: EX lw $8 (ex_write_reg=8, mem_read=1), ID rs=8 → one cycle pc_en=0, ifid_en=0, idex_flush=1, state→LU_STALL; next cycle all enables 1, stall_cycles=1.
- Load to $0: ex_write_reg=0, id_rs=0, mem_read=1 → no stall, state stays RUN, stall_cycles=0.
- Taken branch with load_use asserted the next cycle → cycle 1 ifid_flush=idex_flush=1, flush_count=1, state=FLUSH; cycle 2 load_use masked, pc_en=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, branch_taken=1 throughout → 3 cycles all enables 0, memwb_bubble=1, stall_cycles=3, flush_count=0. Then mem_ready=1 → branch flush fires, flush_count=1.
- Timeout with MAX_WAIT=15: hold mem_ready=0 for 20 cycles → mem_timeout rises in the 15th wait cycle and stays 1 after ready returns. rst → 0.
- Reset mid-MEM_WAIT: rst for 1 cycle → state=RUN, all counters 0; during rst, pc_en=0 and memwb_bubble=1.
